// File: rtl/fp8_to_fixed_if.sv
// fp8_to_fixed_if: operand/result handshake bundle for the minifloat to Q9.10 converter.
interface fp8_to_fixed_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_inf;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_inf);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_inf);
endinterface

// File: rtl/fp8_to_fixed.sv
// fp8_to_fixed: minifloat {s,e4,m3} to signed Q9.10; define FP8_TO_FIXED_FAST_EN for a one-cycle barrel-shift build.
module fp8_to_fixed (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  fp8_to_fixed_if.slave  bus
);
`ifdef FP8_TO_FIXED_FAST_EN
  typedef enum logic {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;
`endif
  state_t      state_q, state_d;
  logic [19:0] out_data_q, out_data_d;
  logic        out_inf_q, out_inf_d;
  logic [3:0]  expo;
  logic [2:0]  mant;
  logic        in_sign;
  logic        is_zero;
  logic        is_inf;
  logic        accept;
  logic [19:0] special;
`ifdef FP8_TO_FIXED_FAST_EN
  logic [19:0] mag_w;
  logic [19:0] fast_data;
`else
  logic [3:0]  cnt_q, cnt_d;
  logic [18:0] mag_q, mag_d;
  logic        sign_q, sign_d;
`endif
  assign expo          = bus.in_data[6:3];
  assign mant          = bus.in_data[2:0];
  assign in_sign       = bus.in_data[7];
  assign is_zero       = expo == 4'd0 && mant == 3'd0;
  assign is_inf        = expo == 4'hF && mant == 3'd0;
  assign special       = is_inf ? (in_sign ? 20'h80001 : 20'h7FFFF) : 20'd0;
  assign bus.in_ready  = ena && !rst_n && state_q == IDLE;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data  = out_data_q;
  assign bus.out_inf   = out_inf_q;
`ifdef FP8_TO_FIXED_FAST_EN
  assign mag_w     = {16'd0, 1'b1, mant} << expo;
  assign fast_data = in_sign ? -mag_w : mag_w;
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_inf_d  = out_inf_q;
    if (ena) begin
      unique case (state_q)
        IDLE: if (accept) begin
          state_d    = DONE;
          out_data_d = (is_zero || is_inf) ? special : fast_data;
          out_inf_d  = is_inf;
        end
        DONE: state_d = bus.out_ready ? IDLE : DONE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_inf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_inf_q  <= out_inf_d;
    end
  end
`else
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_inf_d  = out_inf_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    if (ena) begin
      unique case (state_q)
        IDLE: if (accept) begin
          if (is_zero || is_inf) begin
            state_d    = DONE;
            out_data_d = special;
            out_inf_d  = is_inf;
          end else begin
            state_d = SHIFT;
            mag_d   = {15'd0, 1'b1, mant};
            cnt_d   = expo;
            sign_d  = in_sign;
          end
        end
        SHIFT: begin
          state_d = cnt_q == 4'd0 ? NEG : SHIFT;
          mag_d   = cnt_q == 4'd0 ? mag_q : mag_q << 1;
          cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end
        NEG: begin
          state_d    = DONE;
          out_data_d = sign_q ? -{1'b0, mag_q} : {1'b0, mag_q};
          out_inf_d  = 1'b0;
        end
        DONE: state_d = bus.out_ready ? IDLE : DONE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_inf_q  <= 1'b0;
      cnt_q      <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_inf_q  <= out_inf_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      sign_q     <= sign_d;
    end
  end
`endif
endmodule

// File: doc/fp8_to_fixed.md
FP8_TO_FIXED -- requirements
Module: fp8_to_fixed

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-high despite the name; reset when 1 at a clk edge.
REQ-004 ena  input  1  block enable; when 0 all state holds and in_ready=0.
REQ-005 in_valid  input  1  in_data holds an operand.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  8  minifloat {sign[7], expo[6:3], mant[2:0]}, the format produced by the team's 8-bit FP adder.
REQ-008 out_valid  output  1  out_data/out_inf hold a result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_data  output  20  signed two's-complement fixed point, Q9.10 (value x 1024).
REQ-011 out_inf  output  1  result is saturated (input was infinity code).

Function
REQ-012 Transfers SHALL occur on a clk edge with ena=1: input when in_valid&in_ready, output when out_valid&out_ready.
REQ-013 The block SHALL hold one operand at a time; in_ready=1 only in IDLE with ena=1.
REQ-014 The FSM SHALL have states IDLE, SHIFT, NEG, DONE.
REQ-015 IDLE->SHIFT on accepting a normal operand: mag={1'b1,mant} zero-extended to 19 bits, cnt=expo, sign latched.
REQ-016 SHIFT: cnt==0 -> NEG; otherwise mag<<=1 and cnt-=1 (SHIFT lasts expo+1 cycles).
REQ-017 NEG: out_data = sign ? -{0,mag} : {0,mag} (20-bit); ->DONE.
REQ-018 Normal value SHALL equal 1.mant x 2^(expo-7); raw magnitude {1,mant}<<expo (max 491520) is never truncated.
REQ-019 Zero code (expo=0, mant=0, either sign) SHALL go IDLE->DONE with out_data=0, out_inf=0.
REQ-020 Infinity code (expo=15, mant=0) SHALL go IDLE->DONE with out_data=20'h7FFFF (sign 0) or 20'h80001 (sign 1), out_inf=1.
REQ-021 Other expo=15 codes SHALL be converted as normal values.
REQ-022 Iterative latency: out_valid SHALL rise expo+2 edges after the accepting edge for normal codes and 1 edge after it for zero/infinity.
REQ-023 DONE: out_valid=1; out_data/out_inf stable until handshake; on handshake ->IDLE; in_ready stays 0 in that same cycle (no same-cycle accept).
REQ-024 ena=0 SHALL freeze state, cnt, mag and outputs; out_valid keeps its value, and no transfer occurs even if out_ready=1.
REQ-025 out_valid SHALL be 0 outside DONE; out_data/out_inf keep their last value outside DONE.

Reset
REQ-026 On reset: state=IDLE, out_valid=0, out_data=0, out_inf=0, cnt=0, mag=0; in_ready=0 during the reset cycle.
REQ-027 Reset SHALL dominate ena and any handshake; an in-flight conversion is discarded with no output.

Configuration
REQ-028 Macro FP8_TO_FIXED_FAST_EN: when defined, the SHIFT state is removed and a combinational barrel shift with negation is used; IDLE->DONE for every code, with out_valid 1 edge after the accepting edge.
REQ-029 Without FP8_TO_FIXED_FAST_EN: iterative behaviour per REQ-015..REQ-022; out_data values SHALL be bit-identical in both builds.

Verification
REQ-030 Reset with in_data=8'h3C, in_valid=1 -> in_ready=0, out_valid=0, out_data=0; no accept.
REQ-031 in_data=8'h3C (+,e=7,m=4), out_ready=1 -> out_data=20'h00600 (1.5), out_valid 9 edges after accept (1 edge in fast build).
REQ-032 in_data=8'hF8 (-,e=15,m=0) -> out_data=20'h80001, out_inf=1; in_data=8'h80 -> out_data=0, out_inf=0, both after 1 edge.
REQ-033 in_data=8'h7F (+,e=15,m=7) -> out_data=20'h78000; in_data=8'h81 (-,e=0,m=1) -> out_data=20'hFFFF7 (-9).
REQ-034 out_ready=0 for 5 cycles in DONE, then 1 -> out_valid and out_data held stable, single transfer, in_ready=0 on handshake cycle and 1 the next.
REQ-035 ena dropped for 3 cycles mid-SHIFT -> completion delayed by exactly 3 cycles with a correct value; rst_n=1 mid-SHIFT -> IDLE next edge, no out_valid.
